spi_slave_ctrl: RTL and testbench

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_tx_piso.sv | 52 +++++
 rtl/spi_slave_ctrl.sv | 117 +++++++++++
 tb/tb_spi_slave_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI slave controller: FSM state encoding and frame command codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_pkg;

    // Controller states. IDLE waits for slave select. CHK_CMD samples the command MSB.
    // The remaining states shift in the rest of the frame.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // Two-bit command in rx_data[ADDR_SIZE+1:ADDR_SIZE]
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // The command MSB alone selects write vs. read. A read is treated as a data read
    // only when an address read has already been seen; otherwise it is an address read.
    function automatic state_t cmd_state(input logic cmd_msb, input logic rd_addr_seen);
        if (!cmd_msb) begin
            return WRITE;
        end
        return rd_addr_seen ? READ_DATA : READ_ADD;
    endfunction

endpackage

// File: rtl/spi_tx_piso.sv
// Parallel-in serial-out register that drives read data onto MISO, MSB first.
// Latency: the first bit appears on sout in the cycle after load; one bit per cycle, WIDTH cycles in total.
// Backpressure: none; clear and rst_n abort a shift-out immediately and force sout low.
//
// Ports: clk, rst_n (sync, active-low), clear (sync abort), load + din (parallel word),
//        sout (registered serial out, 0 when idle), last (high during the final bit cycle).
module spi_tx_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             sout,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr_q;    // bits still to be shifted out, next bit at the MSB
    logic [CNT_W-1:0] left_q;  // bits remaining after the one currently on sout
    logic             busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sr_q   <= '0;
            left_q <= '0;
            busy_q <= 1'b0;
            sout   <= 1'b0;
        end else if (load) begin
            // The MSB goes straight to the output register, so it appears in the next cycle.
            sout   <= din[WIDTH-1];
            sr_q   <= {din[WIDTH-2:0], 1'b0};
            left_q <= CNT_W'(WIDTH - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (left_q != '0) begin
                sout   <= sr_q[WIDTH-1];
                sr_q   <= {sr_q[WIDTH-2:0], 1'b0};
                left_q <= left_q - CNT_W'(1);
            end else begin
                sout   <= 1'b0;
                busy_q <= 1'b0;
            end
        end
    end

    // The bit on sout this cycle is the final one.
    assign last = busy_q && (left_q == '0);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave frame decoder: shifts in ADDR_SIZE+2-bit command frames and serialises memory read data onto MISO.
// Latency: rx_valid pulses for one cycle after the edge that samples the last frame bit; MISO starts one cycle after tx_valid is latched.
// Backpressure: none on MOSI; read data waits indefinitely for tx_valid; SS_n=1 aborts everything except rd_addr_seen.
//
// Ports: clk, rst_n (sync, active-low), SS_n (frame select), MOSI/MISO (serial, MSB first),
//        rx_data/rx_valid (received frame + strobe), tx_data/tx_valid (memory read data).
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int W     = ADDR_SIZE + 2;
    localparam int CNT_W = $clog2(W);
    // After CHK_CMD the counter runs 0..ADDR_SIZE. The count ADDR_SIZE samples bit 0.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ADDR_SIZE);

    state_t         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-2:0]   shift_q;        // bits received so far, excluding the one being sampled
    logic           frame_done_q;   // frame complete; hold quietly until SS_n rises
    logic           rd_addr_seen_q;
    logic           rd_wait_q;      // READ_DATA frame done, tx_valid not yet latched

    logic           last_bit;
    logic           piso_load;
    logic           piso_last;

    assign last_bit  = (cnt_q == LAST_CNT);
    assign piso_load = !SS_n && (state_q == READ_DATA) && rd_wait_q && tx_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            frame_done_q   <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            rd_wait_q      <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                // Abort. A partial frame never strobes. The read-address context survives.
                state_q      <= IDLE;
                cnt_q        <= '0;
                shift_q      <= '0;
                frame_done_q <= 1'b0;
                rd_wait_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q      <= CHK_CMD;
                        cnt_q        <= '0;
                        frame_done_q <= 1'b0;
                    end
                    CHK_CMD: begin
                        shift_q <= {{(W-2){1'b0}}, MOSI};
                        cnt_q   <= '0;
                        state_q <= cmd_state(MOSI, rd_addr_seen_q);
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!frame_done_q) begin
                            shift_q <= {shift_q[W-3:0], MOSI};
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (last_bit) begin
                                rx_data      <= {shift_q, MOSI};
                                rx_valid     <= 1'b1;
                                frame_done_q <= 1'b1;
                                if (state_q == READ_ADD) begin
                                    rd_addr_seen_q <= 1'b1;
                                end
                                if (state_q == READ_DATA) begin
                                    rd_wait_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase

                // Only one latch is allowed per read. Later tx_valid pulses are ignored.
                if (piso_load) begin
                    rd_wait_q <= 1'b0;
                end
                // The read sequence closes once the final MISO bit has been presented.
                if (piso_last) begin
                    rd_addr_seen_q <= 1'b0;
                end
            end
        end
    end

    spi_tx_piso #(
        .WIDTH (ADDR_SIZE)
    ) u_tx_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (SS_n),
        .load  (piso_load),
        .din   (tx_data),
        .sout  (MISO),
        .last  (piso_last)
    );

endmodule

// File: tb/tb_spi_slave_ctrl.sv
module tb_spi_slave_ctrl;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    // Running counts of strobe cycles and MISO-high cycles. Tests take snapshots of them.
    int vld_cnt     = 0;
    int miso_hi_cnt = 0;

    spi_slave_ctrl #(.ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (rx_valid === 1'b1) vld_cnt = vld_cnt + 1;
        if (MISO === 1'b1) miso_hi_cnt = miso_hi_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive SS_n low, then the first nbits bits of w, MSB first, one per negedge.
    task automatic drive_frame(input logic [9:0] w, input int nbits);
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int i = 9; i > 9 - nbits; i--) begin
            @(negedge clk);
            MOSI = w[i];
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
        repeat (3) @(negedge clk);
        tests_run++; if (MISO !== 1'b0) begin tests_failed++; $display("FAIL reset_miso: got %b want 0", MISO); end
        tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        tests_run++; if (rx_data !== 10'h000) begin tests_failed++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
        tests_run++; if (dut.state_q !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); end
        tests_run++; if (dut.rd_addr_seen_q !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_seen: got %b want 0", dut.rd_addr_seen_q); end
        SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_addr();
        int bv, bm;
        bv = vld_cnt; bm = miso_hi_cnt;
        drive_frame({CMD_WR_ADDR, 8'h25}, 10);
        @(negedge clk);
        tests_run++; if (rx_valid !== 1'b1) begin tests_failed++; $display("FAIL wa_strobe: got %b want 1", rx_valid); end
        tests_run++; if (rx_data !== 10'h025) begin tests_failed++; $display("FAIL wa_data: got %h want 025", rx_data); end
        @(negedge clk);
        tests_run++; if (rx_valid !== 1'b0) begin tests_failed++; $display("FAIL wa_strobe_len: got %b want 0", rx_valid); end
        repeat (4) @(negedge clk);
        tests_run++; if (vld_cnt - bv != 1) begin tests_failed++; $display("FAIL wa_pulses: got %0d want 1", vld_cnt - bv); end
        tests_run++; if (miso_hi_cnt - bm != 0) begin tests_failed++; $display("FAIL wa_miso: got %0d high cycles want 0", miso_hi_cnt - bm); end
        tests_run++; if (dut.state_q !== WRITE) begin tests_failed++; $display("FAIL wa_state: got %0d want %0d", dut.state_q, WRITE); end
        end_frame();
    endtask

    task automatic test_write_data();
        int bv;
        bv = vld_cnt;
        drive_frame(10'b01_1010_1010, 10);
        repeat (4) @(negedge clk);
        tests_run++; if (vld_cnt - bv != 1) begin tests_failed++; $display("FAIL wd_pulses: got %0d want 1", vld_cnt - bv); end
        tests_run++; if (rx_data !== 10'h1AA) begin tests_failed++; $display("FAIL wd_data: got %h want 1aa", rx_data); end
        end_frame();
    endtask

    task automatic test_read();
        int bm;
        logic [7:0] exp_bits;
        exp_bits = 8'hC3;
        drive_frame(10'b10_0010_0101, 10);
        @(negedge clk);
        tests_run++; if (rx_data !== 10'h225) begin tests_failed++; $display("FAIL rd_addr_data: got %h want 225", rx_data); end
        // tx_valid during an address read must not produce read data
        bm = miso_hi_cnt;
        tx_valid = 1'b1; tx_data = 8'hFF;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        tests_run++; if (miso_hi_cnt - bm != 0) begin tests_failed++; $display("FAIL rd_addr_miso: got %0d high cycles want 0", miso_hi_cnt - bm); end
        tests_run++; if (dut.rd_addr_seen_q !== 1'b1) begin tests_failed++; $display("FAIL rd_addr_seen_set: got %b want 1", dut.rd_addr_seen_q); end
        end_frame();

        drive_frame(10'b11_0000_0000, 10);
        @(negedge clk);
        tests_run++; if (rx_valid !== 1'b1 || rx_data !== 10'h300) begin tests_failed++; $display("FAIL rd_data_frame: got v=%b d=%h want v=1 d=300", rx_valid, rx_data); end
        tests_run++; if (dut.state_q !== READ_DATA) begin tests_failed++; $display("FAIL rd_data_state: got %0d want %0d", dut.state_q, READ_DATA); end
        @(negedge clk);
        bm = miso_hi_cnt;
        tx_valid = 1'b1; tx_data = 8'hC3;
        @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (MISO !== exp_bits[7-i]) begin tests_failed++; $display("FAIL rd_miso_bit%0d: got %b want %b", 7 - i, MISO, exp_bits[7-i]); end
            @(negedge clk);
        end
        tests_run++; if (MISO !== 1'b0) begin tests_failed++; $display("FAIL rd_miso_after: got %b want 0", MISO); end
        tests_run++; if (dut.rd_addr_seen_q !== 1'b0) begin tests_failed++; $display("FAIL rd_seen_clear: got %b want 0", dut.rd_addr_seen_q); end
        // A second tx_valid after the latch is ignored.
        tx_valid = 1'b1; tx_data = 8'hFF;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        tests_run++; if (miso_hi_cnt - bm != 4) begin tests_failed++; $display("FAIL rd_miso_total: got %0d high cycles want 4", miso_hi_cnt - bm); end
        end_frame();
    endtask

    task automatic test_abort();
        int bv;
        bv = vld_cnt;
        drive_frame(10'b01_1111_0000, 5);
        @(negedge clk);
        SS_n = 1'b1;
        @(negedge clk);
        tests_run++; if (dut.state_q !== IDLE) begin tests_failed++; $display("FAIL abort_state: got %0d want %0d", dut.state_q, IDLE); end
        // The abort lands on the edge that would have sampled bit 0.
        drive_frame(10'b00_1111_1111, 9);
        @(negedge clk);
        SS_n = 1'b1; MOSI = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (vld_cnt - bv != 0) begin tests_failed++; $display("FAIL abort_no_strobe: got %0d pulses want 0", vld_cnt - bv); end
        tests_run++; if (rx_data !== 10'h300) begin tests_failed++; $display("FAIL abort_hold: got %h want 300", rx_data); end
        drive_frame(10'b01_0101_0011, 10);
        repeat (2) @(negedge clk);
        tests_run++; if (vld_cnt - bv != 1 || rx_data !== 10'h153) begin tests_failed++; $display("FAIL abort_next: got n=%0d d=%h want n=1 d=153", vld_cnt - bv, rx_data); end
        end_frame();
    endtask

    task automatic test_reset_mid_shift();
        drive_frame(10'b10_0000_0001, 10);
        end_frame();
        drive_frame(10'b11_0000_0000, 10);
        repeat (2) @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        // The negedge that shows bit 7 is the first one. Advance to the fourth bit, MISO bit 3 counted from 0.
        repeat (3) @(negedge clk);
        tests_run++; if (MISO !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_miso: got %b want 1", MISO); end
        rst_n = 1'b0; tx_valid = 1'b1;
        @(negedge clk);
        tests_run++; if (MISO !== 1'b0 || rx_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_out: got miso=%b v=%b want 0 0", MISO, rx_valid); end
        tests_run++; if (dut.rd_addr_seen_q !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_seen: got %b want 0", dut.rd_addr_seen_q); end
        @(negedge clk);
        rst_n = 1'b1; SS_n = 1'b1; tx_valid = 1'b0;
        @(negedge clk);
        drive_frame(10'b11_0000_0000, 10);
        @(negedge clk);
        tests_run++; if (dut.state_q !== READ_ADD) begin tests_failed++; $display("FAIL rst_next_state: got %0d want %0d", dut.state_q, READ_ADD); end
        end_frame();
    endtask

    task automatic test_late_tx_valid();
        int bm;
        logic [7:0] exp_bits;
        exp_bits = 8'h5A;
        // rd_addr_seen is now set from the previous test, so this frame is a data read.
        drive_frame(10'b11_0000_0000, 10);
        @(negedge clk);
        tests_run++; if (dut.state_q !== READ_DATA) begin tests_failed++; $display("FAIL late_state: got %0d want %0d", dut.state_q, READ_DATA); end
        bm = miso_hi_cnt;
        repeat (5) @(negedge clk);
        tests_run++; if (miso_hi_cnt - bm != 0) begin tests_failed++; $display("FAIL late_idle_miso: got %0d high cycles want 0", miso_hi_cnt - bm); end
        tx_valid = 1'b1; tx_data = exp_bits;
        @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (MISO !== exp_bits[7-i]) begin tests_failed++; $display("FAIL late_miso_bit%0d: got %b want %b", 7 - i, MISO, exp_bits[7-i]); end
            @(negedge clk);
        end
        tests_run++; if (MISO !== 1'b0 || dut.rd_addr_seen_q !== 1'b0) begin tests_failed++; $display("FAIL late_end: got miso=%b seen=%b want 0 0", MISO, dut.rd_addr_seen_q); end
        end_frame();
    endtask

    initial begin
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        test_reset();
        test_write_addr();
        test_write_data();
        test_read();
        test_abort();
        test_reset_mid_shift();
        test_late_tx_valid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
